// File: rtl/my_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, LSB-first data,
// one-cycle RX_VALID strobe on a good frame and FRAME_ERR strobe on a bad stop bit.
module my_uart_rx #(
  parameter int CLK_FREQ  = 125_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       FRAME_ERR,
  output logic       BUSY,
  output logic [2:0] dbg_state
);

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [1:0]    sync;
  logic          s;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;
  logic          half_tick;
  logic          bit_tick;

  assign s         = sync[1];
  assign half_tick = (cnt == CW'(HALF - 1));
  assign bit_tick  = (cnt == CW'(CPB - 1));
  assign dbg_state = state;

  // Synchronizer resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (RST) sync <= 2'b11;
    else     sync <= {sync[0], UART_RX};
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= WAIT_HIGH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT_HIGH: if (s) next_state = IDLE;
      IDLE:      if (!s) next_state = START;
      START:     if (half_tick) next_state = s ? IDLE : DATA;
      DATA:      if (bit_tick && bitn == 3'd7) next_state = STOP;
      STOP:      if (bit_tick) next_state = s ? IDLE : WAIT_HIGH;
      default:   next_state = WAIT_HIGH;
    endcase
  end

  // Registered datapath and outputs; BUSY follows next_state so it drops with the strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      bitn      <= '0;
      sh        <= '0;
      RX_DATA   <= 8'h00;
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
      BUSY      <= (next_state == START) || (next_state == DATA) || (next_state == STOP);
      case (state)
        START: begin
          if (half_tick) begin
            cnt  <= '0;
            bitn <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_tick) begin
            sh   <= {s, sh[7:1]};
            cnt  <= '0;
            bitn <= bitn + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_tick) begin
            cnt <= '0;
            if (s) begin
              RX_DATA  <= sh;
              RX_VALID <= 1'b1;
            end else begin
              FRAME_ERR <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
